// File: rtl/sensor_packet_sequencer.sv
// Validates 16-byte sensor packets, holds them in an active/pending double buffer and
// streams the active packet byte-wise. Define SENSOR_SEQ_CHECKSUM_EN to require byte 15 == XOR(bytes 0..14).
module sensor_packet_sequencer #(
  parameter int unsigned STALE_CYCLES = 1_000_000,
  parameter logic [7:0]  HEADER_BYTE  = 8'hAA
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         pkt_strobe,
  input  logic [127:0] pkt_data,
  input  logic         rd_start,
  output logic [7:0]   out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic         pkt_err,
  output logic [15:0]  pkt_count,
  output logic [7:0]   drop_count,
  output logic         stale
);

  localparam int unsigned PKT_W   = 128;
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned STALE_W = (STALE_CYCLES < 1) ? 1 : $clog2(STALE_CYCLES + 1);
  localparam logic [STALE_W-1:0] STALE_MAX = STALE_W'(STALE_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READY  = 2'd1,
    STREAM = 2'd2
  } state_t;

  // Byte i of a packet; byte 0 sits in the top bits.
  function automatic logic [7:0] get_byte(input logic [PKT_W-1:0] p, input logic [IDX_W-1:0] i);
    logic [PKT_W-1:0] s;
    s = p >> {4'd15 - i, 3'b000};
    return s[7:0];
  endfunction

`ifdef SENSOR_SEQ_CHECKSUM_EN
  function automatic logic csum_ok(input logic [PKT_W-1:0] p);
    logic [7:0] x;
    x = 8'd0;
    for (int k = 0; k < 15; k++) x = x ^ get_byte(p, IDX_W'(k));
    return x == p[7:0];
  endfunction
`endif

  state_t             state, state_d;
  logic [IDX_W-1:0]   idx, idx_d;
  logic [PKT_W-1:0]   active, active_d;
  logic [PKT_W-1:0]   pending, pending_d;
  logic               pend_full, pend_full_d;
  logic [7:0]         data_d;
  logic               valid_d, last_d, err_d, stale_d;
  logic [15:0]        count_d;
  logic [7:0]         drop_d;
  logic               drop_inc;
  logic [STALE_W-1:0] stale_cnt, stale_cnt_d;

  logic hdr_ok, sum_ok, accept;

  assign hdr_ok = (pkt_data[127:120] == HEADER_BYTE);
`ifdef SENSOR_SEQ_CHECKSUM_EN
  assign sum_ok = csum_ok(pkt_data);
`else
  assign sum_ok = 1'b1;
`endif
  assign accept = pkt_strobe && hdr_ok && sum_ok;

  // Next-state, buffer and output logic
  always_comb begin
    state_d     = state;
    idx_d       = idx;
    active_d    = active;
    pending_d   = pending;
    pend_full_d = pend_full;
    data_d      = 8'd0;
    valid_d     = 1'b0;
    last_d      = 1'b0;
    drop_inc    = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          active_d = pkt_data;
          state_d  = READY;
        end
      end

      READY: begin
        if (rd_start) begin
          state_d = STREAM;
          idx_d   = 4'd0;
          valid_d = 1'b1;
          data_d  = get_byte(active, 4'd0);
          if (accept) begin
            pending_d   = pkt_data;
            pend_full_d = 1'b1;
            drop_inc    = pend_full;
          end
        end else if (accept) begin
          active_d = pkt_data;
          drop_inc = 1'b1;
        end
      end

      STREAM: begin
        valid_d = 1'b1;
        data_d  = out_data;
        last_d  = out_last;
        if (out_ready && idx == 4'd15) begin
          // Final handshake: a same-cycle arrival wins over anything pending.
          valid_d     = 1'b0;
          data_d      = 8'd0;
          last_d      = 1'b0;
          pending_d   = '0;
          pend_full_d = 1'b0;
          if (accept) begin
            active_d = pkt_data;
            drop_inc = pend_full;
            state_d  = READY;
          end else if (pend_full) begin
            active_d = pending;
            state_d  = READY;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (out_ready) begin
            idx_d  = idx + 4'd1;
            data_d = get_byte(active, idx + 4'd1);
            last_d = (idx == 4'd14);
          end
          if (accept) begin
            pending_d   = pkt_data;
            pend_full_d = 1'b1;
            drop_inc    = pend_full;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    err_d   = pkt_strobe && !accept;
    count_d = pkt_count + 16'(accept);
    drop_d  = (drop_inc && drop_count != 8'hFF) ? drop_count + 8'd1 : drop_count;

    if (accept)                       stale_cnt_d = '0;
    else if (stale_cnt != STALE_MAX)  stale_cnt_d = stale_cnt + STALE_W'(1);
    else                              stale_cnt_d = stale_cnt;
    stale_d = (stale_cnt_d == STALE_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      active     <= '0;
      pending    <= '0;
      pend_full  <= 1'b0;
      out_data   <= 8'd0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      pkt_err    <= 1'b0;
      pkt_count  <= 16'd0;
      drop_count <= 8'd0;
      stale_cnt  <= STALE_MAX;
      stale      <= 1'b1;
    end else begin
      state      <= state_d;
      idx        <= idx_d;
      active     <= active_d;
      pending    <= pending_d;
      pend_full  <= pend_full_d;
      out_data   <= data_d;
      out_valid  <= valid_d;
      out_last   <= last_d;
      pkt_err    <= err_d;
      pkt_count  <= count_d;
      drop_count <= drop_d;
      stale_cnt  <= stale_cnt_d;
      stale      <= stale_d;
    end
  end

endmodule
